pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
Multi-channel, parametrised PWM generator that replaces the single-channel fixed 8-bit PWM in the audio/mic output path. Takes a sample word per channel, keeps the top RES bits, and drives one PWM pin per channel. Adds a clock prescaler and an edge- or centre-aligned counter mode. Duty and mode changes are double-buffered so they apply only at a period boundary, which gives glitch-free updates. A valid/ready handshake lets an upstream sample source stall until the pending update has been consumed.

Parameters:
CHANNELS, 2, number of PWM outputs (>=1)
IN_WIDTH, 12, width of each channel's input sample
RES, 8, PWM resolution in bits (RES <= IN_WIDTH); duty = sample[IN_WIDTH-1 -: RES]
PRESCALE_W, 8, width of prescale input

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run PWM; low = counters held at 0, outputs low
prescale  in  PRESCALE_W  counter advances once every prescale+1 clocks
center_mode  in  1  0 = edge-aligned sawtooth, 1 = centre-aligned triangle
duty_in  in  CHANNELS*IN_WIDTH  packed samples; channel k at [k*IN_WIDTH +: IN_WIDTH]
duty_valid  in  1  duty_in valid
duty_ready  out  1  pending shadow empty; transfer occurs when valid && ready
period_start  out  1  one-cycle pulse when a new PWM period begins
pwm_out  out  CHANNELS  PWM outputs, registered

Behaviour:
- Reset values: prescale counter 0; main counter 0; direction up; active duty 0; pending duty 0; pending_full 0; active mode 0 (edge-aligned).
- Reset output values: pwm_out 0, period_start 0, duty_ready 1.
- Tick: asserted in a cycle when enable=1 and prescale_cnt==prescale. prescale_cnt then returns to 0; otherwise it increments.
- A prescale change mid-count takes effect through that comparison. If prescale_cnt > prescale, the count wraps through its maximum value; this is acceptable and documented.
- Edge mode: on each tick the counter goes 0..MAX (MAX = 2^RES-1) and wraps to 0. Period = 2^RES ticks. Boundary = tick with counter==MAX.
- Centre mode: on each tick the counter counts up 0..MAX, then down MAX-1..1, then returns to 0. Direction flips at MAX and at 1 going down. Period = 2*MAX ticks. Boundary = tick with counter==1 and direction down.
- Boundary actions, on the same clock edge the counter becomes 0:
  - If pending_full, pending is copied to active and pending_full clears.
  - active mode takes center_mode.
  - direction resets to up.
  - period_start is registered high for exactly one cycle.
- Handshake:
  - duty_ready = !pending_full.
  - On valid && ready, pending captures all channels' top RES bits and pending_full sets.
  - If a capture and a boundary coincide, the boundary consumes the old pending, and the new capture leaves pending_full set with the new data.
- Output: pwm_out[k] <= (active[k] > counter), registered, so there is 1 clock of latency from the counter value.
  - duty 0 gives constant low.
  - duty MAX gives high for all counts except MAX (edge mode) or except the MAX apex tick (centre mode).
- enable=0:
  - Counters, direction, and prescale_cnt are forced to 0/up; pwm_out is 0; period_start is 0.
  - The handshake still operates, and pending is copied to active every cycle, so a restart uses the latest duty immediately.
  - On enable rising, the first period starts at counter 0 with no period_start pulse for that first period.
- A reset asserted mid-period clears everything asynchronously. Outputs drop to 0 with no clock required.
- All duty arithmetic is unsigned. Extra low-order input bits are discarded, not rounded.

Decomposition:
- Shared package pwm_pkg holds:
  - mode encoding constants PWM_MODE_EDGE=0 and PWM_MODE_CENTER=1;
  - helper function duty_slice(sample) returning the top RES bits.
- One natural sub-module is pwm_timebase: prescaler, up/down counter, direction, tick, boundary and period_start. It is shared by all channels.
- The top level holds per-channel pending/active registers, the handshake logic, and a generate loop of comparators and output flops.

Test Plan:
- Edge, prescale=0, ch0 duty_in=12'h800, ch1=12'h000 -> ch0 high 128 of every 256 clocks (1-clock offset); ch1 always low; period_start every 256 clocks.
- Edge, prescale=3, duty_in=12'hFFF -> period 1024 clocks; pwm high 1020 clocks, low 4 clocks per period.
- Centre, prescale=0, duty_in=12'h400 (duty 0x40) -> period 510 clocks; high 127 clocks, centred on counter 0; output symmetric around the boundary.
- Mid-period write of 12'h200 at counter=0x30 (old duty 0x80) -> pwm_out unchanged until the boundary; next period high 32 clocks; duty_ready low from the write until the boundary.
- Two back-to-back writes within one period -> the second is held with duty_ready=0 and accepted the cycle after the boundary; no update is lost.
- Reset pulse mid-period, and enable low for 10 clocks -> pwm_out=0 immediately; on release the counter restarts at 0 and the latest duty applies in the first period.

Source files
------------

// File: rtl/pwm_multi_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the multi-channel PWM block.
//   PWM_MODE_EDGE / PWM_MODE_CENTER : counter mode encoding
//   SLICE_W                         : working width of the duty slicing helper
//   duty_slice()                    : keeps the top 'res' bits of an 'in_width'
//                                     sample (truncation, no rounding)
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam logic PWM_MODE_EDGE   = 1'b0;
    localparam logic PWM_MODE_CENTER = 1'b1;

    // Samples are zero-extended to this width before slicing; IN_WIDTH must
    // not exceed it.
    localparam int SLICE_W = 32;

    // Right-align the top 'res' bits of an 'in_width'-bit sample. Low-order
    // bits are simply discarded. Callers truncate the result to 'res' bits.
    function automatic logic [SLICE_W-1:0] duty_slice(
        input logic [SLICE_W-1:0] sample,
        input int unsigned        in_width,
        input int unsigned        res
    );
        return sample >> (in_width - res);
    endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// -----------------------------------------------------------------------------
// pwm_multi_if
// Valid/ready duty-sample channel feeding pwm_multi.
//   duty_in    : packed samples, channel k at [k*IN_WIDTH +: IN_WIDTH]
//   duty_valid : duty_in holds a new sample set
//   duty_ready : the PWM can accept a sample set (pending shadow empty)
// Modports: master = sample source, slave = PWM block.
// -----------------------------------------------------------------------------
interface pwm_multi_if #(
    parameter int CHANNELS = 2,
    parameter int IN_WIDTH = 12
);

    logic [CHANNELS*IN_WIDTH-1:0] duty_in;
    logic                         duty_valid;
    logic                         duty_ready;

    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );

endinterface

// File: rtl/pwm_multi_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
// Shared time base for all PWM channels: prescaler, up/down period counter,
// direction, period boundary detection and the period_start pulse.
//   clock, reset     : system clock, asynchronous active-high reset
//   i_enable         : low holds prescaler/counter at 0, direction up
//   i_prescale       : counter advances once every i_prescale+1 clocks
//   i_center_mode    : mode sampled at each period boundary
//   o_cnt            : current counter value
//   o_boundary       : combinational, high on the tick that ends a period
//   o_period_start   : registered one-cycle pulse, high while counter is 0
//                      at the start of a new period
// Requires RES >= 2.
// -----------------------------------------------------------------------------
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int RES        = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_enable,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic                  i_center_mode,
    output logic [RES-1:0]        o_cnt,
    output logic                  o_boundary,
    output logic                  o_period_start
);

    localparam logic [RES-1:0]        CNT_MAX = {RES{1'b1}};
    localparam logic [RES-1:0]        CNT_ONE = {{(RES-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic [RES-1:0]        r_cnt;
    logic                  r_dir_down;
    logic                  r_mode;
    logic                  r_period_start;

    logic                  w_tick;
    logic                  w_boundary;
    logic [RES-1:0]        w_cnt_next;
    logic                  w_dir_next;

    // A prescale value lowered below the running count makes the prescaler
    // wrap through its maximum before the next tick; this is accepted.
    assign w_tick = i_enable && (r_pre_cnt == i_prescale);

    // Period end: edge mode at MAX, centre mode at 1 while counting down.
    assign w_boundary = w_tick &&
                        ((r_mode == PWM_MODE_EDGE) ? (r_cnt == CNT_MAX)
                                                   : (r_dir_down && (r_cnt == CNT_ONE)));

    // Next counter value and direction, applied only on a tick.
    always_comb begin
        w_cnt_next = r_cnt;
        w_dir_next = r_dir_down;
        if (w_boundary) begin
            w_cnt_next = '0;
            w_dir_next = 1'b0;
        end else if (r_mode == PWM_MODE_EDGE) begin
            w_cnt_next = r_cnt + CNT_ONE;
            w_dir_next = 1'b0;
        end else if (!r_dir_down) begin
            if (r_cnt == CNT_MAX) begin
                // Apex: turn around without repeating MAX.
                w_cnt_next = r_cnt - CNT_ONE;
                w_dir_next = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CNT_ONE;
                w_dir_next = 1'b0;
            end
        end else begin
            w_cnt_next = r_cnt - CNT_ONE;
            w_dir_next = 1'b1;
        end
    end

    // Prescaler, counter, direction, latched mode and period_start pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pre_cnt      <= '0;
            r_cnt          <= '0;
            r_dir_down     <= 1'b0;
            r_mode         <= PWM_MODE_EDGE;
            r_period_start <= 1'b0;
        end else if (!i_enable) begin
            // The restart after enable rises begins at 0 and is not flagged
            // by period_start.
            r_pre_cnt      <= '0;
            r_cnt          <= '0;
            r_dir_down     <= 1'b0;
            r_mode         <= r_mode;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_boundary;
            if (w_tick) begin
                r_pre_cnt  <= '0;
                r_cnt      <= w_cnt_next;
                r_dir_down <= w_dir_next;
            end else begin
                r_pre_cnt  <= r_pre_cnt + PRE_ONE;
                r_cnt      <= r_cnt;
                r_dir_down <= r_dir_down;
            end
            if (w_boundary) begin
                r_mode <= i_center_mode;
            end else begin
                r_mode <= r_mode;
            end
        end
    end

    assign o_cnt          = r_cnt;
    assign o_boundary     = w_boundary;
    assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi
// Multi-channel PWM generator with double-buffered duty updates.
//   clock, reset    : system clock, asynchronous active-high reset
//   i_enable        : run PWM; low holds the time base and drives outputs low
//   i_prescale      : counter advances once every i_prescale+1 clocks
//   i_center_mode   : 0 edge-aligned sawtooth, 1 centre-aligned triangle
//   s_duty          : valid/ready sample channel (slave side)
//   o_period_start  : one-cycle pulse at the start of each new period
//   o_pwm_out       : registered PWM outputs, one per channel
// A captured sample set waits in the pending shadow and moves to the active
// duty only at a period boundary (or at once while disabled), so outputs
// never glitch mid-period.
// -----------------------------------------------------------------------------
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int IN_WIDTH   = 12,
    parameter int RES        = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_enable,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic                  i_center_mode,
    pwm_multi_if.slave            s_duty,
    output logic                  o_period_start,
    output logic [CHANNELS-1:0]   o_pwm_out
);

    logic [CHANNELS-1:0][RES-1:0] r_pending;
    logic [CHANNELS-1:0][RES-1:0] r_active;
    logic                         r_pending_full;
    logic [CHANNELS-1:0]          r_pwm;

    logic [CHANNELS-1:0][RES-1:0] w_slice;
    logic [CHANNELS-1:0]          w_cmp;
    logic [RES-1:0]               w_cnt;
    logic                         w_boundary;
    logic                         w_xfer;
    logic                         w_load;

    pwm_timebase #(
        .RES        (RES),
        .PRESCALE_W (PRESCALE_W)
    ) u_timebase (
        .clock          (clock),
        .reset          (reset),
        .i_enable       (i_enable),
        .i_prescale     (i_prescale),
        .i_center_mode  (i_center_mode),
        .o_cnt          (w_cnt),
        .o_boundary     (w_boundary),
        .o_period_start (o_period_start)
    );

    assign w_xfer = s_duty.duty_valid && !r_pending_full;
    // While disabled the shadow drains every cycle so a restart begins with
    // the most recent duty.
    assign w_load = w_boundary || !i_enable;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign w_slice[k] = RES'(duty_slice(SLICE_W'(s_duty.duty_in[k*IN_WIDTH +: IN_WIDTH]),
                                            IN_WIDTH, RES));
        assign w_cmp[k]   = (r_active[k] > w_cnt);
    end

    // Pending/active duty shadows and the handshake flag. A capture can only
    // happen while the shadow is empty, so it never collides with a copy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending      <= '0;
            r_active       <= '0;
            r_pending_full <= 1'b0;
        end else begin
            if (w_load && r_pending_full) begin
                r_active <= r_pending;
            end else begin
                r_active <= r_active;
            end
            if (w_xfer) begin
                r_pending      <= w_slice;
                r_pending_full <= 1'b1;
            end else if (w_load) begin
                r_pending      <= r_pending;
                r_pending_full <= 1'b0;
            end else begin
                r_pending      <= r_pending;
                r_pending_full <= r_pending_full;
            end
        end
    end

    // Output flops: one clock behind the counter value they compare against.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pwm <= '0;
        end else if (i_enable) begin
            r_pwm <= w_cmp;
        end else begin
            r_pwm <= '0;
        end
    end

    assign s_duty.duty_ready = !r_pending_full;
    assign o_pwm_out         = r_pwm;

endmodule

// File: tb/tb_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi
// Directed bench for pwm_multi (2 channels, 12-bit samples, 8-bit resolution).
// Each PWM period is measured from one period_start pulse to the next; the
// length, high counts per channel and not-ready cycles are compared with
// hand-computed values. A sample source process presents queued writes on
// the valid/ready channel.
// -----------------------------------------------------------------------------
module tb_pwm_multi;

    localparam int CH = 2;
    localparam int IW = 12;
    localparam int RS = 8;
    localparam int PW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [PW-1:0] prescale;
    logic          center_mode;
    logic          period_start;
    logic [CH-1:0] pwm_out;

    pwm_multi_if #(.CHANNELS(CH), .IN_WIDTH(IW)) duty_if ();

    pwm_multi #(
        .CHANNELS   (CH),
        .IN_WIDTH   (IW),
        .RES        (RS),
        .PRESCALE_W (PW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .i_enable       (enable),
        .i_prescale     (prescale),
        .i_center_mode  (center_mode),
        .s_duty         (duty_if),
        .o_period_start (period_start),
        .o_pwm_out      (pwm_out)
    );

    always #5 clock = ~clock;

    int          n_vec      = 0;
    int          n_miss     = 0;
    int          n_pushed   = 0;
    int          n_accepted = 0;
    logic [23:0] wr_q[$];
    logic        rdy_seen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic queue_write(input logic [11:0] w0, input logic [11:0] w1);
        wr_q.push_back({w0, w1});
        n_pushed++;
    endtask

    // Sample source: runs just after each rising edge. A word presented while
    // ready was high at the previous edge has been taken, so drop it and
    // present the next one.
    initial begin
        logic [23:0] item;
        duty_if.duty_valid = 1'b0;
        duty_if.duty_in    = '0;
        rdy_seen           = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (duty_if.duty_valid && rdy_seen) begin
                duty_if.duty_valid = 1'b0;
                n_accepted++;
            end
            if (!duty_if.duty_valid && wr_q.size() > 0) begin
                item               = wr_q.pop_front();
                duty_if.duty_in    = {item[11:0], item[23:12]};
                duty_if.duty_valid = 1'b1;
            end
            rdy_seen = duty_if.duty_ready;
        end
    end

    // Measure from the current falling edge up to (not including) the next
    // one that shows period_start. Optionally queues a write at sample wr_at.
    // Returns positioned on that period_start sample.
    task automatic win(input string tag, input int wr_at,
                       input logic [11:0] w0, input logic [11:0] w1,
                       input int e_len, input int e_h0, input int e_h1,
                       input int e_nrdy, input int e_s0, input int e_s1);
        int   len, h0, h1, nrdy;
        logic s0, s1;
        len = 0; h0 = 0; h1 = 0; nrdy = 0;
        s0 = pwm_out[0];
        s1 = 1'b0;
        do begin
            if (len == wr_at) queue_write(w0, w1);
            if (len == 1) s1 = pwm_out[0];
            h0   += pwm_out[0] ? 1 : 0;
            h1   += pwm_out[1] ? 1 : 0;
            nrdy += duty_if.duty_ready ? 0 : 1;
            len++;
            @(negedge clock);
        end while (!period_start && len < 4000);
        check_val({tag, ".len"}, len, e_len);
        if (e_h0 >= 0)   check_val({tag, ".hi0"}, h0, e_h0);
        if (e_h1 >= 0)   check_val({tag, ".hi1"}, h1, e_h1);
        if (e_nrdy >= 0) check_val({tag, ".nrdy"}, nrdy, e_nrdy);
        if (e_s0 >= 0)   check_val({tag, ".s0"}, s0, e_s0);
        if (e_s1 >= 0)   check_val({tag, ".s1"}, s1, e_s1);
    endtask

    initial begin
        int ps_cnt;
        reset       = 1'b1;
        enable      = 1'b0;
        prescale    = 8'd0;
        center_mode = 1'b0;
        repeat (3) @(negedge clock);
        check_val("rst.pwm", pwm_out, 2'b00);
        check_val("rst.ps", period_start, 1'b0);
        check_val("rst.rdy", duty_if.duty_ready, 1'b1);

        // Write while disabled: copied straight to active.
        reset = 1'b0;
        @(negedge clock);
        queue_write(12'h800, 12'h000);
        repeat (5) @(negedge clock);
        check_val("dis.rdy", duty_if.duty_ready, 1'b1);
        check_val("dis.pwm", pwm_out, 2'b00);

        // Edge, prescale 0, duty 0x80/0x00. First period has no leading pulse.
        enable = 1'b1;
        win("edge.first", -1, 12'h0, 12'h0, 256, 128, 0, 0, -1, -1);
        win("edge.steady", -1, 12'h0, 12'h0, 256, 128, 0, 0, 0, 1);

        // Prescale 3 with duty 0xFF: old duty finishes this period first.
        prescale = 8'd3;
        win("ps3.old", 0, 12'hFFF, 12'hFFF, 1024, 512, 0, 1022, -1, -1);
        win("ps3.full", -1, 12'h0, 12'h0, 1024, 1020, 1020, 0, 0, 1);

        // Switch to centre mode with duty 0x40; this period is still edge.
        prescale    = 8'd0;
        center_mode = 1'b1;
        win("ctr.pre", 0, 12'h400, 12'h000, 256, 255, 255, 254, -1, -1);
        // First triangle: its first output sample still reflects the edge
        // period's MAX, so one high cycle is missing.
        win("ctr.first", -1, 12'h0, 12'h0, 510, 126, 0, 0, -1, -1);
        // Steady triangle; request edge mode + new duty for the next period.
        center_mode = 1'b0;
        win("ctr.steady", 0, 12'h800, 12'h8FF, 510, 127, 0, 508, 1, 1);

        // Edge again with 0x80 / 0x8F (low nibble of 0x8FF discarded).
        win("mid.settle", -1, 12'h0, 12'h0, 256, -1, -1, 0, -1, -1);
        win("mid.write", 8'h30, 12'h200, 12'h000, 256, 128, 143, 206, 0, 1);
        win("mid.new", -1, 12'h0, 12'h0, 256, 32, 0, 0, -1, -1);

        // Two writes in one period: the second waits for the boundary.
        queue_write(12'hC00, 12'h100);
        queue_write(12'h3FF, 12'hFFF);
        win("b2b.old", -1, 12'h0, 12'h0, 256, 32, 0, 254, -1, -1);
        win("b2b.first", -1, 12'h0, 12'h0, 256, 192, 16, 255, -1, -1);
        win("b2b.second", -1, 12'h0, 12'h0, 256, 63, 255, 0, -1, -1);

        // Reset in mid-period drops outputs without a clock edge.
        repeat (100) @(negedge clock);
        check_val("rstmid.pre", pwm_out, 2'b10);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        check_val("rstmid.pwm", pwm_out, 2'b00);
        check_val("rstmid.rdy", duty_if.duty_ready, 1'b1);
        check_val("rstmid.ps", period_start, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        queue_write(12'hC00, 12'h100);
        repeat (10) @(negedge clock);
        check_val("rstrel.pwm", pwm_out, 2'b00);
        check_val("rstrel.rdy", duty_if.duty_ready, 1'b1);
        enable = 1'b1;
        win("rstrel.run", -1, 12'h0, 12'h0, 256, 192, 16, 0, -1, -1);

        // Enable low for 10 clocks mid-period with a new duty written meanwhile.
        repeat (50) @(negedge clock);
        enable = 1'b0;
        queue_write(12'hFFF, 12'h000);
        ps_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            ps_cnt += period_start ? 1 : 0;
        end
        check_val("enlow.pwm", pwm_out, 2'b00);
        check_val("enlow.ps", ps_cnt, 0);
        enable = 1'b1;
        win("enlow.restart", -1, 12'h0, 12'h0, 256, 255, 0, 0, -1, -1);

        check_val("writes.accepted", n_accepted, n_pushed);
        check_val("writes.queue", wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
